// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_addsub_unit_fa.sv
// One-bit full adder built from two gate-level half adders and an OR.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    logic s1, c1, c2;

    // first half adder: a + b
    xor g_ha1_s (s1, a, b);
    and g_ha1_c (c1, a, b);
    // second half adder: partial sum + carry in
    xor g_ha2_s (sum, s1, c_in);
    and g_ha2_c (c2, s1, c_in);
    // at most one half adder can generate a carry
    or  g_cout  (c_out, c1, c2);
endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract: one full-adder cell, LSB first, WIDTH cycles per result.
module serial_addsub_unit
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
    logic             cy_q, cy_d, c_out_q, c_out_d, ovf_q, ovf_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             fa_s, fa_c, last, load;

    full_adder_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .c_in (cy_q),
        .sum  (fa_s),
        .c_out(fa_c)
    );

    assign last = (idx_q == IDX_W'(WIDTH - 1));
    // start is only honoured when no operation is in flight
    assign load = start && (state_q == ST_IDLE || state_q == ST_DONE);

    // next-state and datapath updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cy_d    = cy_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = {fa_s, r_q[WIDTH-1:1]};
                cy_d  = fa_c;
                idx_d = idx_q + IDX_W'(1);
                if (last) begin
                    // cy_q here is the carry into the MSB
                    sum_d   = r_d;
                    c_out_d = fa_c;
                    ovf_d   = cy_q ^ fa_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // subtraction is a + ~b + 1: invert b and seed the carry with 1
        if (load) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            cy_d    = sub;
            idx_d   = '0;
            state_d = ST_RUN;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cy_q    <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cy_q    <= cy_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench: directed WIDTH=4 cases plus randomized WIDTH=8 against an arithmetic model.
module tb_serial_addsub_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // WIDTH=4 instance
    logic       rst4 = 1'b1, start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       busy4, done4, cout4, ovf4;
    // WIDTH=8 instance
    logic       rst8 = 1'b1, start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, cout8, ovf8;

    serial_addsub_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .ovf(ovf4)
    );
    serial_addsub_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .ovf(ovf8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input int w, input longint a, input longint b, input bit sub,
                         output longint s, output bit c, output bit v);
        longint m, sa, sb, r;
        m  = (longint'(1) << w);
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (sub) begin
            s = (a - b + m) % m;
            c = (a >= b);
            r = sa - sb;
        end else begin
            s = (a + b) % m;
            c = ((a + b) >= m);
            r = sa + sb;
        end
        v = (r > m / 2 - 1) || (r < -(m / 2));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done on dut4; cyc = edges since call, nbusy = busy samples seen.
    task automatic wait4(output int cyc, output int nbusy);
        cyc = 0; nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (i == 0) start4 = 1'b0;
            if (done4) return;
            if (busy4) nbusy++;
        end
        chk("w4_timeout", 1, 0);
    endtask

    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b, input bit sub);
        int cyc, nb;
        longint s; bit c, v;
        model(4, longint'(a), longint'(b), sub, s, c, v);
        a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
        wait4(cyc, nb);
        chk({tag, "_sum"}, sum4, s);
        chk({tag, "_cout"}, cout4, c);
        chk({tag, "_ovf"}, ovf4, v);
        chk({tag, "_lat"}, cyc, 5);
        chk({tag, "_busy"}, nb, 4);
        tick();
        chk({tag, "_pulse"}, done4, 0);
    endtask

    initial begin
        int cyc, nb, ndone;
        longint s; bit c, v;

        // reset held two cycles
        tick(); tick();
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_sum", sum4, 0);
        chk("rst_cout", cout4, 0);
        chk("rst_ovf", ovf4, 0);
        rst4 = 1'b0;
        tick();

        op4("add7_9", 4'd7, 4'd9, 1'b0);
        op4("sub5_3", 4'd5, 4'd3, 1'b1);
        op4("sub3_5", 4'd3, 4'd5, 1'b1);
        op4("add7_1", 4'd7, 4'd1, 1'b0);
        op4("sub8_1", 4'h8, 4'd1, 1'b1);
        op4("sub0_0", 4'd0, 4'd0, 1'b1);

        // start mid-RUN ignored, then start held through DONE for back-to-back
        a4 = 4'd2; b4 = 4'd3; sub4 = 1'b0; start4 = 1'b1;
        tick(); start4 = 1'b0;
        tick();
        a4 = 4'd9; b4 = 4'd9; sub4 = 1'b1; start4 = 1'b1;
        tick(); start4 = 1'b0;
        a4 = 4'd1; b4 = 4'd1; sub4 = 1'b0; start4 = 1'b1;
        cyc = 0;
        for (int i = 0; i < 20 && !done4; i++) tick();
        chk("ign_done", done4, 1);
        chk("ign_sum", sum4, 4'd5);
        chk("ign_cout", cout4, 0);
        wait4(cyc, nb);
        chk("b2b_gap", cyc, 5);
        chk("b2b_sum", sum4, 4'd2);
        tick();

        // reset while idx==2 aborts the op
        a4 = 4'd3; b4 = 4'd4; sub4 = 1'b0; start4 = 1'b1;
        tick(); start4 = 1'b0;
        tick(); tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        chk("abort_sum", sum4, 0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done4) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        op4("after_abort", 4'd6, 4'd5, 1'b0);

        // WIDTH=8 randomized
        rst8 = 1'b0;
        tick();
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] ra, rb;
            bit rs;
            int k;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            model(8, longint'(ra), longint'(rb), rs, s, c, v);
            a8 = ra; b8 = rb; sub8 = rs; start8 = 1'b1;
            tick();
            start8 = 1'b0;
            // latched copies only: scramble the inputs during the run
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            k = 1;
            while (!done8 && k < 30) begin
                tick();
                k++;
            end
            chk("r8_lat", k, 9);
            chk("r8_sum", sum8, s);
            chk("r8_cout", cout8, c);
            chk("r8_ovf", ovf8, v);
            tick();
            chk("r8_pulse", done8, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    // global watchdog
    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
